hazard_ctrl: RTL and testbench

- Parametrised successor to the single-cycle hazard unit of the 5-stage MIPS pipeline.
- Sequential hazard controller:
  - multi-bubble load-use stall sequencing
  - configurable branch-resolution stage and flush depth
  - data-memory wait tracking
  - halt drain state machine
  - saturating performance counters
- Drives per-register enable/flush vectors and PC select for the datapath.

---
 rtl/hazard_pkg.sv | 36 +++
 rtl/hazard_ctrl_if.sv | 44 ++++
 rtl/hz_sat_counter.sv | 22 ++
 rtl/hazard_ctrl.sv | 176 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Pipe-register indices match the bit positions of en_pipe/flush_pipe.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LU_STALL   = 2'd1,
    HALT_DRAIN = 2'd2,
    HALTED     = 2'd3
  } hz_state_t;

  typedef enum logic [1:0] {
    HZ_PC_NEXT   = 2'd0,
    HZ_PC_BRANCH = 2'd1,
    HZ_PC_JUMP   = 2'd2
  } hz_pc_sel_t;

  localparam int IDX_IF_ID     = 0;
  localparam int IDX_ID_EX     = 1;
  localparam int IDX_EX_MEM    = 2;
  localparam int IDX_MEM_WB    = 3;
  localparam int NUM_PIPE_REGS = 4;

  // Register $0 never carries a real dependency, so it is excluded here.
  function automatic logic load_use_match(
    input logic       load,
    input logic [4:0] rt_ex,
    input logic [4:0] rs_id,
    input logic [4:0] rt_id,
    input logic       uses_rt
  );
    return load && (rt_ex != 5'd0) &&
           ((rt_ex == rs_id) || (uses_rt && (rt_ex == rt_id)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of hazard-controller signals; hc is the controller side, tb the driver side.
interface hazard_ctrl_if
  import hazard_pkg::*;
#(
  parameter int PERF_W = 32
) (
  input logic clk
);

  logic              rst;
  logic              ihit;
  logic              dhit;
  logic              dmemREN;
  logic              dmemWEN;
  logic              load_ID_EX;
  logic [4:0]        Rt_ID_EX;
  logic [4:0]        Rs_IF_ID;
  logic [4:0]        Rt_IF_ID;
  logic              uses_rt_IF_ID;
  logic              jump_IF_ID;
  logic              branch_taken;
  logic              halt_IF_ID;
  logic [3:0]        en_pipe;
  logic [3:0]        flush_pipe;
  logic              enable_pc;
  hz_pc_sel_t        pc_sel;
  logic              halted;
  logic [PERF_W-1:0] stall_cycles;
  logic [PERF_W-1:0] redirect_events;

  modport hc (
    input  clk, rst, ihit, dhit, dmemREN, dmemWEN, load_ID_EX, Rt_ID_EX,
           Rs_IF_ID, Rt_IF_ID, uses_rt_IF_ID, jump_IF_ID, branch_taken, halt_IF_ID,
    output en_pipe, flush_pipe, enable_pc, pc_sel, halted, stall_cycles, redirect_events
  );

  modport tb (
    input  clk, en_pipe, flush_pipe, enable_pc, pc_sel, halted, stall_cycles,
           redirect_events,
    output rst, ihit, dhit, dmemREN, dmemWEN, load_ID_EX, Rt_ID_EX, Rs_IF_ID,
           Rt_IF_ID, uses_rt_IF_ID, jump_IF_ID, branch_taken, halt_IF_ID
  );

endinterface

// File: rtl/hz_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module hz_sat_counter #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              clr,
  output logic [PERF_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {PERF_W{1'b1}})) begin
      count <= count + PERF_W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Sequential hazard controller: load-use bubbles, branch/jump redirect,
// memory-wait freeze and halt drain, with saturating performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int BRANCH_STAGE     = 2,
  parameter int DRAIN_CYCLES     = 3,
  parameter int PERF_W           = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic              load_ID_EX,
  input  logic [4:0]        Rt_ID_EX,
  input  logic [4:0]        Rs_IF_ID,
  input  logic [4:0]        Rt_IF_ID,
  input  logic              uses_rt_IF_ID,
  input  logic              jump_IF_ID,
  input  logic              branch_taken,
  input  logic              halt_IF_ID,
  output logic [3:0]        en_pipe,
  output logic [3:0]        flush_pipe,
  output logic              enable_pc,
  output hz_pc_sel_t        pc_sel,
  output logic              halted,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] redirect_events
);

  localparam int DCW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [1:0] LU_INIT =
    2'((LOAD_USE_BUBBLES > 1) ? LOAD_USE_BUBBLES - 2 : 0);
  localparam logic [DCW-1:0] DRAIN_INIT =
    DCW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  hz_state_t      state_reg;
  logic [1:0]     cnt_reg;
  logic [DCW-1:0] dcnt_reg;

  logic mem_req;
  logic adv;
  logic mem_done;
  logic lu_hazard;
  logic in_run;
  logic stall_inc;
  logic redirect_inc;
  logic [NUM_PIPE_REGS-1:0] branch_mask;

  assign mem_req   = dmemREN | dmemWEN;
  assign adv       = ihit & ~(mem_req & ~dhit);
  assign mem_done  = mem_req & dhit & ~ihit;
  assign in_run    = (state_reg == RUN);
  assign lu_hazard = load_use_match(load_ID_EX, Rt_ID_EX, Rs_IF_ID, Rt_IF_ID,
                                    uses_rt_IF_ID);
  assign halted    = (state_reg == HALTED);

  // A taken branch squashes every register younger than the branch itself.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PIPE_REGS; gi++) begin : g_branch_mask
      assign branch_mask[gi] = (gi <= BRANCH_STAGE) ? 1'b1 : 1'b0;
    end
  endgenerate

  always_comb begin
    en_pipe      = 4'b0000;
    flush_pipe   = 4'b0000;
    enable_pc    = 1'b0;
    pc_sel       = HZ_PC_NEXT;
    stall_inc    = 1'b0;
    redirect_inc = 1'b0;
    if (RST || (state_reg == HALTED)) begin
      en_pipe = 4'b0000;
    end else if (!adv) begin
      // A finished data access lets the back end move on while fetch waits.
      if (mem_done) begin
        en_pipe               = 4'b1110;
        flush_pipe[IDX_ID_EX] = 1'b1;
      end else begin
        stall_inc = 1'b1;
      end
    end else begin
      en_pipe   = 4'b1111;
      enable_pc = 1'b1;
      if (branch_taken) begin
        flush_pipe   = branch_mask;
        pc_sel       = HZ_PC_BRANCH;
        redirect_inc = 1'b1;
      end else if ((in_run && lu_hazard) || (state_reg == LU_STALL)) begin
        enable_pc             = 1'b0;
        en_pipe[IDX_IF_ID]    = 1'b0;
        flush_pipe[IDX_ID_EX] = 1'b1;
        stall_inc             = 1'b1;
      end else if ((in_run && halt_IF_ID) || (state_reg == HALT_DRAIN)) begin
        enable_pc             = 1'b0;
        flush_pipe[IDX_IF_ID] = 1'b1;
      end else if (in_run && jump_IF_ID) begin
        pc_sel                = HZ_PC_JUMP;
        flush_pipe[IDX_IF_ID] = 1'b1;
        redirect_inc          = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= RUN;
      cnt_reg   <= 2'd0;
      dcnt_reg  <= '0;
    end else if (adv && (state_reg != HALTED)) begin
      if (branch_taken) begin
        state_reg <= RUN;
      end else begin
        case (state_reg)
          RUN: begin
            if (lu_hazard) begin
              if (LOAD_USE_BUBBLES > 1) begin
                state_reg <= LU_STALL;
                cnt_reg   <= LU_INIT;
              end
            end else if (halt_IF_ID) begin
              if (DRAIN_CYCLES == 0) begin
                state_reg <= HALTED;
              end else begin
                state_reg <= HALT_DRAIN;
                dcnt_reg  <= DRAIN_INIT;
              end
            end
          end
          LU_STALL: begin
            if (cnt_reg == 2'd0) begin
              state_reg <= RUN;
            end else begin
              cnt_reg <= cnt_reg - 2'd1;
            end
          end
          HALT_DRAIN: begin
            if (dcnt_reg == '0) begin
              state_reg <= HALTED;
            end else begin
              dcnt_reg <= dcnt_reg - DCW'(1);
            end
          end
          default: begin
            state_reg <= state_reg;
          end
        endcase
      end
    end
  end

  hz_sat_counter #(
    .PERF_W (PERF_W)
  ) u_stall_cnt (
    .clk   (CLK),
    .rst   (RST),
    .inc   (stall_inc),
    .clr   (1'b0),
    .count (stall_cycles)
  );

  hz_sat_counter #(
    .PERF_W (PERF_W)
  ) u_redirect_cnt (
    .clk   (CLK),
    .rst   (RST),
    .inc   (redirect_inc),
    .clr   (1'b0),
    .count (redirect_events)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: vector table, hand sequences for multi-cycle cases,
// and randomized cycles against a rule-level reference model.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int LUB = 2;
  localparam int BS  = 2;
  localparam int DC  = 3;
  localparam int PW  = 4;
  localparam int SAT = (1 << PW) - 1;

  typedef struct {
    logic       ihit, dhit, ren, wen, load;
    logic [4:0] rt_ex, rs_id, rt_id;
    logic       uses_rt, jump, br, halt;
  } stim_t;

  typedef struct {
    string      name;
    stim_t      s;
    logic [3:0] en, fl;
    logic       pce;
    hz_pc_sel_t sel;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.PERF_W(PW)) hif (.clk(clk));

  hazard_ctrl #(
    .LOAD_USE_BUBBLES (LUB),
    .BRANCH_STAGE     (BS),
    .DRAIN_CYCLES     (DC),
    .PERF_W           (PW)
  ) dut (
    .CLK             (clk),
    .RST             (hif.rst),
    .ihit            (hif.ihit),
    .dhit            (hif.dhit),
    .dmemREN         (hif.dmemREN),
    .dmemWEN         (hif.dmemWEN),
    .load_ID_EX      (hif.load_ID_EX),
    .Rt_ID_EX        (hif.Rt_ID_EX),
    .Rs_IF_ID        (hif.Rs_IF_ID),
    .Rt_IF_ID        (hif.Rt_IF_ID),
    .uses_rt_IF_ID   (hif.uses_rt_IF_ID),
    .jump_IF_ID      (hif.jump_IF_ID),
    .branch_taken    (hif.branch_taken),
    .halt_IF_ID      (hif.halt_IF_ID),
    .en_pipe         (hif.en_pipe),
    .flush_pipe      (hif.flush_pipe),
    .enable_pc       (hif.enable_pc),
    .pc_sel          (hif.pc_sel),
    .halted          (hif.halted),
    .stall_cycles    (hif.stall_cycles),
    .redirect_events (hif.redirect_events)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: remaining bubbles, remaining drain cycles (-1 = idle).
  int m_lu, m_drain, m_stall, m_redir;
  bit m_halted;
  int nx_lu, nx_drain, nx_stall, nx_redir;
  bit nx_halted;

  vec_t vq[$];

  function automatic stim_t mk(input logic ih, dh, rn, wn, ld,
                               input logic [4:0] rte, rs, rt,
                               input logic ur, jp, br, hl);
    stim_t s;
    s.ihit = ih; s.dhit = dh; s.ren = rn; s.wen = wn; s.load = ld;
    s.rt_ex = rte; s.rs_id = rs; s.rt_id = rt;
    s.uses_rt = ur; s.jump = jp; s.br = br; s.halt = hl;
    return s;
  endfunction

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  task automatic drive(input stim_t s);
    hif.ihit = s.ihit; hif.dhit = s.dhit; hif.dmemREN = s.ren; hif.dmemWEN = s.wen;
    hif.load_ID_EX = s.load; hif.Rt_ID_EX = s.rt_ex; hif.Rs_IF_ID = s.rs_id;
    hif.Rt_IF_ID = s.rt_id; hif.uses_rt_IF_ID = s.uses_rt; hif.jump_IF_ID = s.jump;
    hif.branch_taken = s.br; hif.halt_IF_ID = s.halt;
  endtask

  function automatic logic [31:0] comb_vec();
    return {21'd0, hif.en_pipe, hif.flush_pipe, hif.enable_pc, hif.pc_sel};
  endfunction

  function automatic logic [31:0] full_vec();
    return {12'd0, hif.en_pipe, hif.flush_pipe, hif.enable_pc, hif.pc_sel,
            hif.halted, hif.stall_cycles, hif.redirect_events};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%h", name, act);
    end
  endtask

  task automatic model_reset();
    m_lu = 0; m_drain = -1; m_halted = 1'b0; m_stall = 0; m_redir = 0;
  endtask

  task automatic model_commit();
    m_lu = nx_lu; m_drain = nx_drain; m_halted = nx_halted;
    m_stall = nx_stall; m_redir = nx_redir;
  endtask

  task automatic model_cycle(input stim_t s, output logic [3:0] e_en,
                             output logic [3:0] e_fl, output logic e_pce,
                             output hz_pc_sel_t e_sel);
    bit mem_req, adv, lu, in_run;
    e_en = 4'h0; e_fl = 4'h0; e_pce = 1'b0; e_sel = HZ_PC_NEXT;
    nx_lu = m_lu; nx_drain = m_drain; nx_halted = m_halted;
    nx_stall = m_stall; nx_redir = m_redir;
    if (m_halted) return;
    mem_req = s.ren || s.wen;
    adv     = s.ihit && !(mem_req && !s.dhit);
    in_run  = (m_lu == 0) && (m_drain < 0);
    lu      = s.load && (s.rt_ex != 0) &&
              ((s.rt_ex == s.rs_id) || (s.uses_rt && (s.rt_ex == s.rt_id)));
    if (!adv) begin
      if (mem_req && s.dhit && !s.ihit) begin
        e_en = 4'b1110; e_fl = 4'b0010;
      end else begin
        nx_stall = sat(m_stall + 1);
      end
      return;
    end
    e_en = 4'b1111; e_pce = 1'b1;
    if (s.br) begin
      for (int i = 0; i <= BS; i++) e_fl[i] = 1'b1;
      e_sel = HZ_PC_BRANCH;
      nx_lu = 0; nx_drain = -1;
      nx_redir = sat(m_redir + 1);
    end else if (m_lu > 0 || (in_run && lu)) begin
      e_en[0] = 1'b0; e_pce = 1'b0; e_fl[1] = 1'b1;
      nx_stall = sat(m_stall + 1);
      nx_lu = (m_lu > 0) ? m_lu - 1 : LUB - 1;
    end else if (m_drain >= 0 || (in_run && s.halt)) begin
      e_pce = 1'b0; e_fl[0] = 1'b1;
      if (m_drain < 0) nx_drain = DC - 1;
      else if (m_drain == 0) begin nx_halted = 1'b1; nx_drain = -1; end
      else nx_drain = m_drain - 1;
    end else if (s.jump) begin
      e_sel = HZ_PC_JUMP; e_fl[0] = 1'b1;
      nx_redir = sat(m_redir + 1);
    end
  endtask

  task automatic do_reset();
    hif.rst = 1'b1;
    drive(mk(1,0,0,0,0, 5'd0,5'd0,5'd0, 0,0,0,0));
    #1;
    check("reset_outputs", full_vec(), 32'd0);
    @(posedge clk);
    @(negedge clk);
    hif.rst = 1'b0;
    model_reset();
  endtask

  task automatic cyc(input string name, input stim_t s, input logic [3:0] en,
                     input logic [3:0] fl, input logic pce, input hz_pc_sel_t sel);
    drive(s);
    #1;
    check(name, comb_vec(), {21'd0, en, fl, pce, sel});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add_vec(input string name, input stim_t s, input logic [3:0] en,
                         input logic [3:0] fl, input logic pce, input hz_pc_sel_t sel);
    vec_t v;
    v.name = name; v.s = s; v.en = en; v.fl = fl; v.pce = pce; v.sel = sel;
    vq.push_back(v);
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s.ihit    = ($urandom_range(7) != 0);
    s.dhit    = $urandom_range(1) == 1;
    s.ren     = ($urandom_range(3) == 0);
    s.wen     = ($urandom_range(5) == 0);
    s.load    = ($urandom_range(2) == 0);
    s.rt_ex   = 5'($urandom_range(3));
    s.rs_id   = 5'($urandom_range(3));
    s.rt_id   = 5'($urandom_range(3));
    s.uses_rt = $urandom_range(1) == 1;
    s.jump    = ($urandom_range(7) == 0);
    s.br      = ($urandom_range(9) == 0);
    s.halt    = ($urandom_range(39) == 0);
    return s;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t base, lu;
    logic [3:0] e_en, e_fl;
    logic e_pce;
    hz_pc_sel_t e_sel;
    int since, halt_age;

    hif.rst = 1'b1;
    drive(mk(0,0,0,0,0, 5'd0,5'd0,5'd0, 0,0,0,0));
    base = mk(1,0,0,0,0, 5'd5,5'd1,5'd2, 0,0,0,0);
    lu   = mk(1,0,0,0,1, 5'd5,5'd5,5'd2, 0,0,0,0);
    @(negedge clk);

    // Single-cycle decisions straight out of reset.
    add_vec("adv_default",     base,                                        4'hF, 4'h0, 1, HZ_PC_NEXT);
    add_vec("zero_load",       mk(1,0,0,0,1, 5'd0,5'd0,5'd0, 1,0,0,0),      4'hF, 4'h0, 1, HZ_PC_NEXT);
    add_vec("lu_rs",           lu,                                          4'hE, 4'h2, 0, HZ_PC_NEXT);
    add_vec("lu_rt",           mk(1,0,0,0,1, 5'd5,5'd1,5'd5, 1,0,0,0),      4'hE, 4'h2, 0, HZ_PC_NEXT);
    add_vec("rt_not_used",     mk(1,0,0,0,1, 5'd5,5'd1,5'd5, 0,0,0,0),      4'hF, 4'h0, 1, HZ_PC_NEXT);
    add_vec("branch",          mk(1,0,0,0,0, 5'd5,5'd1,5'd2, 0,0,1,0),      4'hF, 4'h7, 1, HZ_PC_BRANCH);
    add_vec("jump",            mk(1,0,0,0,0, 5'd5,5'd1,5'd2, 0,1,0,0),      4'hF, 4'h1, 1, HZ_PC_JUMP);
    add_vec("halt",            mk(1,0,0,0,0, 5'd5,5'd1,5'd2, 0,0,0,1),      4'hF, 4'h1, 0, HZ_PC_NEXT);
    add_vec("ifetch_wait",     mk(0,0,0,0,0, 5'd5,5'd1,5'd2, 0,0,0,0),      4'h0, 4'h0, 0, HZ_PC_NEXT);
    add_vec("load_wait",       mk(1,0,1,0,0, 5'd5,5'd1,5'd2, 0,0,0,0),      4'h0, 4'h0, 0, HZ_PC_NEXT);
    add_vec("store_wait",      mk(1,0,0,1,0, 5'd5,5'd1,5'd2, 0,0,0,0),      4'h0, 4'h0, 0, HZ_PC_NEXT);
    add_vec("mem_done_noih",   mk(0,1,1,0,0, 5'd5,5'd1,5'd2, 0,0,0,0),      4'hE, 4'h2, 0, HZ_PC_NEXT);
    add_vec("mem_done_ih",     mk(1,1,1,0,0, 5'd5,5'd1,5'd2, 0,0,0,0),      4'hF, 4'h0, 1, HZ_PC_NEXT);
    add_vec("lu_beats_jump",   mk(1,0,0,0,1, 5'd5,5'd5,5'd2, 0,1,0,0),      4'hE, 4'h2, 0, HZ_PC_NEXT);
    add_vec("branch_beats_lu", mk(1,0,0,0,1, 5'd5,5'd5,5'd2, 0,0,1,0),      4'hF, 4'h7, 1, HZ_PC_BRANCH);
    add_vec("halt_beats_jump", mk(1,0,0,0,0, 5'd5,5'd1,5'd2, 0,1,0,1),      4'hF, 4'h1, 0, HZ_PC_NEXT);
    add_vec("branch_in_wait",  mk(1,0,1,0,0, 5'd5,5'd1,5'd2, 0,0,1,0),      4'h0, 4'h0, 0, HZ_PC_NEXT);

    foreach (vq[i]) begin
      do_reset();
      drive(vq[i].s);
      #1;
      check(vq[i].name, comb_vec(), {21'd0, vq[i].en, vq[i].fl, vq[i].pce, vq[i].sel});
    end

    // Two-bubble load-use, then back to normal flow.
    do_reset();
    cyc("lu_bubble1", lu, 4'hE, 4'h2, 0, HZ_PC_NEXT);
    cyc("lu_bubble2", lu, 4'hE, 4'h2, 0, HZ_PC_NEXT);
    check("lu_stall_count", 32'(hif.stall_cycles), 32'd2);
    cyc("lu_resume", base, 4'hF, 4'h0, 1, HZ_PC_NEXT);

    // Branch resolving while the second bubble is pending.
    do_reset();
    cyc("lub_bubble1", lu, 4'hE, 4'h2, 0, HZ_PC_NEXT);
    cyc("lub_branch", mk(1,0,0,0,1, 5'd5,5'd5,5'd2, 0,0,1,0), 4'hF, 4'h7, 1, HZ_PC_BRANCH);
    check("lub_redirects", 32'(hif.redirect_events), 32'd1);
    cyc("lub_run", base, 4'hF, 4'h0, 1, HZ_PC_NEXT);
    check("lub_stall_count", 32'(hif.stall_cycles), 32'd1);

    // Data memory wait, completing while fetch is still outstanding.
    do_reset();
    for (int i = 0; i < 3; i++)
      cyc($sformatf("memwait%0d", i), mk(1,0,1,0,0, 5'd5,5'd1,5'd2, 0,0,0,0),
          4'h0, 4'h0, 0, HZ_PC_NEXT);
    cyc("memwait_done", mk(0,1,1,0,0, 5'd5,5'd1,5'd2, 0,0,0,0), 4'hE, 4'h2, 0, HZ_PC_NEXT);
    check("memwait_stall_count", 32'(hif.stall_cycles), 32'd3);

    // Halt decode, drain, halted, then asynchronous reset release.
    do_reset();
    cyc("halt_decode", mk(1,0,0,0,0, 5'd5,5'd1,5'd2, 0,0,0,1), 4'hF, 4'h1, 0, HZ_PC_NEXT);
    for (int i = 0; i < DC; i++)
      cyc($sformatf("halt_drain%0d", i), base, 4'hF, 4'h1, 0, HZ_PC_NEXT);
    check("halted_set", {31'd0, hif.halted}, 32'd1);
    cyc("halted_frozen0", base, 4'h0, 4'h0, 0, HZ_PC_NEXT);
    cyc("halted_frozen1", mk(1,0,0,0,0, 5'd5,5'd1,5'd2, 0,1,1,0), 4'h0, 4'h0, 0, HZ_PC_NEXT);
    check("halted_held", {31'd0, hif.halted}, 32'd1);
    #2;
    hif.rst = 1'b1;
    #1;
    check("async_rst_clears_halted", {31'd0, hif.halted}, 32'd0);
    do_reset();

    // Long freeze saturates the stall counter.
    for (int i = 0; i < 20; i++) begin
      drive(mk(0,0,0,0,0, 5'd5,5'd1,5'd2, 0,0,0,0));
      @(posedge clk);
      @(negedge clk);
    end
    check("stall_saturates", 32'(hif.stall_cycles), 32'(SAT));

    // Randomized traffic against the reference model.
    do_reset();
    since = 0;
    halt_age = 0;
    for (int t = 0; t < 1500; t++) begin
      stim_t s;
      if (since >= 60 || halt_age >= 3) begin
        do_reset();
        since = 0;
        halt_age = 0;
      end
      s = rand_stim();
      drive(s);
      #1;
      model_cycle(s, e_en, e_fl, e_pce, e_sel);
      check($sformatf("rnd%0d", t), full_vec(),
            {12'd0, e_en, e_fl, e_pce, e_sel, m_halted, PW'(m_stall), PW'(m_redir)});
      @(posedge clk);
      model_commit();
      @(negedge clk);
      since++;
      if (m_halted) halt_age++;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
